// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle datapath (master) and its controller (slave).
interface multicycle_control_if;
  logic [5:0] Op;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       MemtoReg;
  logic       IRWrite;
  logic [1:0] PCSource;
  logic [1:0] ALUop;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic       RegDst;
  logic [3:0] State;
  logic       IllegalOp;

  modport master (
    output Op,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    input  PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, State, IllegalOp
  );

  modport slave (
    input  Op,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
    output PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, State, IllegalOp
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS subset (R-type, j, beq, addi, lw, sw).
// Controls decode from the state register; write strobes are squashed while reset is high.
module multicycle_control (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);
  localparam int unsigned STATE_W = 4;
  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RCOMPL   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_e;

  // Plain vector so codes 12-15 stay representable and recover to FETCH.
  logic [STATE_W-1:0] r_state;
  logic               r_illegal;

  logic       w_pcwrite, w_pcwritecond, w_iord, w_memread, w_memwrite;
  logic       w_memtoreg, w_irwrite, w_alusrca, w_regwrite, w_regdst;
  logic [1:0] w_pcsource, w_aluop, w_alusrcb;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= 1'b0;
      case (r_state)
        S_FETCH:    r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.Op)
            OP_LW, OP_SW: r_state <= S_MEMADDR;
            OP_R:         r_state <= S_REXEC;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            OP_ADDI:      r_state <= S_ADDIEXEC;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADDR: begin
          if (bus.Op == OP_LW)      r_state <= S_MEMREAD;
          else if (bus.Op == OP_SW) r_state <= S_MEMWRITE;
          else                      r_state <= S_FETCH;
        end
        S_MEMREAD:  r_state <= S_MEMWB;
        S_REXEC:    r_state <= S_RCOMPL;
        S_ADDIEXEC: r_state <= S_ADDIWB;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Per-state control decode; anything not named for a state stays 0.
  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_memtoreg    = 1'b0;
    w_irwrite     = 1'b0;
    w_alusrca     = 1'b0;
    w_regwrite    = 1'b0;
    w_regdst      = 1'b0;
    w_pcsource    = 2'b00;
    w_aluop       = 2'b00;
    w_alusrcb     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_memread = 1'b1;
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        w_alusrcb = 2'b01;
      end
      S_DECODE:   w_alusrcb = 2'b11;
      S_MEMADDR, S_ADDIEXEC: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
      end
      S_MEMREAD: begin
        w_memread = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
      end
      S_MEMWRITE: begin
        w_memwrite = 1'b1;
        w_iord     = 1'b1;
      end
      S_REXEC: begin
        w_alusrca = 1'b1;
        w_aluop   = 2'b10;
      end
      S_RCOMPL: begin
        w_regwrite = 1'b1;
        w_regdst   = 1'b1;
      end
      S_BRANCH: begin
        w_alusrca     = 1'b1;
        w_aluop       = 2'b01;
        w_pcwritecond = 1'b1;
        w_pcsource    = 2'b01;
      end
      S_JUMP: begin
        w_pcwrite  = 1'b1;
        w_pcsource = 2'b10;
      end
      S_ADDIWB:   w_regwrite = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCWrite     = w_pcwrite & ~reset;
  assign bus.PCWriteCond = w_pcwritecond & ~reset;
  assign bus.MemRead     = w_memread & ~reset;
  assign bus.MemWrite    = w_memwrite & ~reset;
  assign bus.IRWrite     = w_irwrite & ~reset;
  assign bus.RegWrite    = w_regwrite & ~reset;
  assign bus.IorD        = w_iord;
  assign bus.MemtoReg    = w_memtoreg;
  assign bus.PCSource    = w_pcsource;
  assign bus.ALUop       = w_aluop;
  assign bus.ALUSrcA     = w_alusrca;
  assign bus.ALUSrcB     = w_alusrcb;
  assign bus.RegDst      = w_regdst;
  assign bus.State       = r_state;
  assign bus.IllegalOp   = r_illegal;
endmodule
